fifo_capture_ctrl: RTL and testbench
====================================

FIFO_CAPTURE_CTRL -- requirements
Module: fifo_capture_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles fifo_rst_o is held high before capture starts.
REQ-002 SHALL have parameter CNT_W, default 32: width of length, divider and captured-count registers.
REQ-003 SHALL have ports sys_clk_i (in, 1), the single clock, and sys_rst_i (in, 1); reset is synchronous and active-high.
REQ-004 SHALL have sys_addr_i (in, 32), sys_wdata_i (in, 32), sys_sel_i (in, 4, ignored), sys_wen_i (in, 1) and sys_ren_i (in, 1): bus request.
REQ-005 SHALL have sys_rdata_o (out, 32), sys_ack_o (out, 1) and sys_err_o (out, 1): bus response.
REQ-006 SHALL have fifo_rst_o (out, 1), fifo_wr_en_o (out, 1) and fifo_rd_en_o (out, 1): FIFO control.
REQ-007 SHALL have fifo_dout_i (in, 64), fifo_full_i (in, 1) and fifo_empty_i (in, 1): FIFO read data and flags; the FIFO runs on sys_clk_i and its dout is valid 1 cycle after rd_en.
REQ-008 SHALL have cnt_clr_o (out, 1) and cnt_en_o (out, 1): clear and enable for the timestamp counter feeding the FIFO din.

Function
REQ-009 SHALL decode sys_addr_i[19:0] into these registers:
- 0x00 CTRL (W): bit0 start, bit1 abort, bit2 clear sticky flags; all self-clearing.
- 0x04 LEN (R/W): number of words to capture.
- 0x08 DIV (R/W): one sample every DIV+1 cycles.
- 0x0C STATUS (R): {23'h0, data_valid, underflow, overflow, fifo_empty_i, fifo_full_i, 1'b0, state[2:0]}.
- 0x10 POP (W, data ignored).
- 0x14 CAPTURED (R).
- 0x18 DATA_LO (R).
- 0x1C DATA_HI (R).
REQ-010 SHALL register sys_ack_o = sys_wen_i|sys_ren_i one cycle after the request at a decoded address; at any other address it SHALL drive sys_ack_o=1 and sys_rdata_o=32'hffffffff; sys_err_o SHALL be 0 always.
REQ-011 SHALL implement states IDLE=0, FLUSH=1, CAPTURE=2, DONE=3 and POP=4.
REQ-012 IDLE/DONE + start: SHALL go to FLUSH, zero CAPTURED, clear data_valid and the divider counter, and assert fifo_rst_o and cnt_clr_o.
REQ-013 FLUSH: SHALL hold fifo_rst_o and cnt_clr_o high for exactly RST_CYCLES cycles, then go to CAPTURE.
REQ-014 CAPTURE: SHALL hold cnt_en_o=1; the divider SHALL count 0..DIV and, on reaching DIV, emit a one-cycle strobe and wrap to 0.
REQ-015 Strobe with fifo_full_i=0: SHALL pulse fifo_wr_en_o for 1 cycle and increment CAPTURED.
REQ-016 Strobe with fifo_full_i=1: SHALL NOT write, SHALL set sticky overflow, and SHALL go to DONE.
REQ-017 CAPTURED reaching LEN: SHALL go to DONE with cnt_en_o=0 the next cycle; LEN=0 SHALL go to DONE directly from FLUSH with no writes.
REQ-018 Abort in any state: SHALL go to IDLE the next cycle with fifo_wr_en_o, fifo_rd_en_o, fifo_rst_o and cnt_en_o all 0; abort SHALL take priority over a start in the same write.
REQ-019 POP write in IDLE/DONE with fifo_empty_i=0: SHALL pulse fifo_rd_en_o for 1 cycle, enter POP, latch fifo_dout_i into DATA_HI/LO on the next cycle, set data_valid, and return to the originating state.
REQ-020 POP write with fifo_empty_i=1: SHALL set sticky underflow, produce no rd_en, and leave DATA unchanged.
REQ-021 POP writes in FLUSH/CAPTURE/POP, and start writes in FLUSH/CAPTURE/POP, SHALL be ignored.
REQ-022 Clear-flags SHALL zero overflow, underflow and data_valid; if it coincides with an event that sets a flag, the flag SHALL end set.
REQ-023 CAPTURED SHALL saturate at all-ones; the divider SHALL be CNT_W bits wide, so DIV=0 yields a strobe every cycle.

Reset
REQ-024 While sys_rst_i=1 at a clock edge: state=IDLE; LEN, DIV, CAPTURED, DATA and all flags = 0; every FIFO/counter output = 0; sys_ack_o=0 and sys_rdata_o=0.
REQ-025 sys_rst_i asserted mid-CAPTURE SHALL stop writes from the next edge; no fifo_rst_o is issued until the next start.

Verification
REQ-026 LEN=5, DIV=2, start -> fifo_rst_o high 4 cycles, then 5 wr_en pulses spaced 3 cycles, state=3, CAPTURED=5.
REQ-027 fifo_full_i forced 1 after 2 writes, LEN=10 -> CAPTURED=2, overflow=1, state=3, no further wr_en.
REQ-028 DONE, fifo_dout_i=64'h0123_4567_89AB_CDEF, POP -> one rd_en pulse, DATA_LO=0x89ABCDEF, DATA_HI=0x01234567, data_valid=1.
REQ-029 POP with fifo_empty_i=1 -> underflow=1, no rd_en; then CTRL=0x4 -> STATUS bits[8:6]=0.
REQ-030 Abort written 3 cycles into CAPTURE with DIV=0 -> CAPTURED stays at the value reached, state=0 the next cycle, cnt_en_o=0.
REQ-031 Read of 0x20 -> sys_ack_o=1, sys_rdata_o=0xffffffff; CTRL=0x3 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/fifo_capture_ctrl_if.sv
// fifo_capture_ctrl_if
//   Register-bus bundle between a bus master and fifo_capture_ctrl.
//   Request : sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i
//   Response: sys_rdata_o, sys_ack_o, sys_err_o
//   The _i/_o suffixes are taken from the controller's point of view.
interface fifo_capture_ctrl_if;
  logic [31:0] sys_addr_i;
  logic [31:0] sys_wdata_i;
  logic [3:0]  sys_sel_i;
  logic        sys_wen_i;
  logic        sys_ren_i;
  logic [31:0] sys_rdata_o;
  logic        sys_ack_o;
  logic        sys_err_o;

  modport master (
    output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_ack_o, sys_err_o
  );

  modport slave (
    input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_ack_o, sys_err_o
  );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// fifo_capture_ctrl
//   Sequences a timestamp-capture FIFO: flushes FIFO and counter, writes one
//   sample every DIV+1 cycles until LEN words are stored or the FIFO fills,
//   and lets software pop words back out through DATA_HI/DATA_LO.
// Ports
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   bus                  : register bus (slave modport)
//   fifo_rst_o, fifo_wr_en_o, fifo_rd_en_o : FIFO control
//   fifo_dout_i, fifo_full_i, fifo_empty_i : FIFO read data and flags
//   cnt_clr_o, cnt_en_o  : timestamp counter clear / enable
//
// state   | meaning
// IDLE    | waiting for start or pop
// FLUSH   | FIFO and counter held in reset for RST_CYCLES cycles
// CAPTURE | counter running, one FIFO write per divider strobe
// DONE    | capture finished (length reached or overflow)
// POP     | one-cycle wait for FIFO read data, then back to IDLE/DONE
module fifo_capture_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  fifo_capture_ctrl_if.slave bus,
  output logic               fifo_rst_o,
  output logic               fifo_wr_en_o,
  output logic               fifo_rd_en_o,
  input  logic [63:0]        fifo_dout_i,
  input  logic               fifo_full_i,
  input  logic               fifo_empty_i,
  output logic               cnt_clr_o,
  output logic               cnt_en_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_POP     = 3'd4
  } state_t;

  localparam int FL_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_LEN    = 20'h04;
  localparam logic [19:0] A_DIV    = 20'h08;
  localparam logic [19:0] A_STATUS = 20'h0C;
  localparam logic [19:0] A_POP    = 20'h10;
  localparam logic [19:0] A_CAPT   = 20'h14;
  localparam logic [19:0] A_DLO    = 20'h18;
  localparam logic [19:0] A_DHI    = 20'h1C;

  state_t            state, state_nxt, pop_ret;
  logic [FL_W-1:0]   flush_cnt;
  logic [CNT_W-1:0]  len_q, div_q, div_cnt, captured;
  logic [63:0]       data_q;
  logic              ovf_q, unf_q, dv_q;
  logic [31:0]       rdata_q, rd_mux;
  logic              ack_q;

  logic [19:0] addr;
  logic        addr_hit;
  logic        wr_ctrl, wr_len, wr_div, pop_req;
  logic        start_req, abort_req, clr_req;
  logic        strobe, pop_latch;
  logic        start_go, pop_go, unf_set, ovf_set, wr_go;
  logic [2:0]  state_bits;
  logic        unused_bits;

  assign addr       = bus.sys_addr_i[19:0];
  assign addr_hit   = (addr[19:5] == '0) && (addr[1:0] == 2'b00);
  assign wr_ctrl    = bus.sys_wen_i && (addr == A_CTRL);
  assign wr_len     = bus.sys_wen_i && (addr == A_LEN);
  assign wr_div     = bus.sys_wen_i && (addr == A_DIV);
  assign pop_req    = bus.sys_wen_i && (addr == A_POP);
  // abort wins over a start carried in the same CTRL write
  assign abort_req  = wr_ctrl && bus.sys_wdata_i[1];
  assign start_req  = wr_ctrl && bus.sys_wdata_i[0] && !bus.sys_wdata_i[1];
  assign clr_req    = wr_ctrl && bus.sys_wdata_i[2];
  // >= keeps the divider sane if DIV is lowered mid-capture
  assign strobe     = (state == S_CAPTURE) && (div_cnt >= div_q);
  assign pop_latch  = (state == S_POP);
  assign state_bits = state;
  assign unused_bits = ^{bus.sys_sel_i, bus.sys_addr_i[31:20]};

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    pop_go    = 1'b0;
    unf_set   = 1'b0;
    ovf_set   = 1'b0;
    wr_go     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_req) begin
          state_nxt = S_FLUSH;
          start_go  = 1'b1;
        end else if (pop_req) begin
          if (fifo_empty_i) begin
            unf_set = 1'b1;
          end else begin
            pop_go    = 1'b1;
            state_nxt = S_POP;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) state_nxt = (len_q == '0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (captured >= len_q) begin
          state_nxt = S_DONE;
        end else if (strobe) begin
          if (fifo_full_i) begin
            ovf_set   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            wr_go = 1'b1;
            if ((captured + ONE) == len_q) state_nxt = S_DONE;
          end
        end
      end
      S_POP:   state_nxt = pop_ret;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req) begin
      state_nxt = S_IDLE;
      pop_go    = 1'b0;
      unf_set   = 1'b0;
      ovf_set   = 1'b0;
      wr_go     = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '1;
    case (addr)
      A_CTRL, A_POP: rd_mux = '0;
      A_LEN:         rd_mux = 32'(len_q);
      A_DIV:         rd_mux = 32'(div_q);
      A_STATUS:      rd_mux = {23'h0, dv_q, unf_q, ovf_q, fifo_empty_i,
                               fifo_full_i, 1'b0, state_bits};
      A_CAPT:        rd_mux = 32'(captured);
      A_DLO:         rd_mux = data_q[31:0];
      A_DHI:         rd_mux = data_q[63:32];
      default:       rd_mux = '1;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state     <= S_IDLE;
      pop_ret   <= S_IDLE;
      flush_cnt <= '0;
      len_q     <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      captured  <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dv_q      <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (pop_go) pop_ret <= state;
      if (start_go)                                  flush_cnt <= FL_LOAD;
      else if (state == S_FLUSH && flush_cnt != '0)  flush_cnt <= flush_cnt - FL_W'(1);
      if (start_go)                div_cnt <= '0;
      else if (state == S_CAPTURE) div_cnt <= strobe ? '0 : div_cnt + ONE;
      if (start_go)                      captured <= '0;
      else if (wr_go && captured != '1)  captured <= captured + ONE;
      if (wr_len) len_q <= CNT_W'(bus.sys_wdata_i);
      if (wr_div) div_q <= CNT_W'(bus.sys_wdata_i);
      if (pop_latch) data_q <= fifo_dout_i;
      // a set event in the same cycle as clear leaves the flag set
      ovf_q <= (ovf_q & ~clr_req) | ovf_set;
      unf_q <= (unf_q & ~clr_req) | unf_set;
      dv_q  <= (dv_q & ~clr_req & ~start_go) | pop_latch;
      ack_q <= bus.sys_wen_i | bus.sys_ren_i;
      if (bus.sys_ren_i) rdata_q <= addr_hit ? rd_mux : '1;
    end
  end

  assign fifo_rst_o   = (state == S_FLUSH);
  assign cnt_clr_o    = (state == S_FLUSH);
  assign cnt_en_o     = (state == S_CAPTURE);
  assign fifo_wr_en_o = wr_go  & ~sys_rst_i;
  assign fifo_rd_en_o = pop_go & ~sys_rst_i;

  assign bus.sys_rdata_o = rdata_q;
  assign bus.sys_ack_o   = ack_q;
  assign bus.sys_err_o   = 1'b0;

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// tb_fifo_capture_ctrl
//   Directed bench for fifo_capture_ctrl: register reads are checked through
//   an expectation queue, FIFO/counter pins through negedge pulse counters.
module tb_fifo_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rst, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic        cnt_clr, cnt_en;
  logic [63:0] fifo_dout = '0;
  logic [63:0] pop_value;
  logic        rd_seen = 1'b0;

  always #5 clk = ~clk;

  fifo_capture_ctrl_if bus ();

  fifo_capture_ctrl #(.RST_CYCLES(4), .CNT_W(32)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .bus          (bus),
    .fifo_rst_o   (fifo_rst),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_dout_i  (fifo_dout),
    .fifo_full_i  (fifo_full),
    .fifo_empty_i (fifo_empty),
    .cnt_clr_o    (cnt_clr),
    .cnt_en_o     (cnt_en)
  );

  int cyc = 0, wr_cnt = 0, rd_cnt = 0, rst_cnt = 0, clr_cnt = 0;
  int wr_time[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_time.push_back(cyc);
    end
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rst)   rst_cnt <= rst_cnt + 1;
    if (cnt_clr)    clr_cnt <= clr_cnt + 1;
    rd_seen <= fifo_rd_en;
  end

  // FIFO read port: data appears the cycle after rd_en
  always @(posedge clk) if (rd_seen) fifo_dout <= pop_value;

  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr_i  = a;
    bus.sys_wdata_i = d;
    bus.sys_wen_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_wen_i   = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.sys_addr_i = a;
    bus.sys_ren_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_ren_i  = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_ack"}, 64'(bus.sys_ack_o), 64'd1);
    chk(t, 64'(bus.sys_rdata_o), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, cb, rdb, n;
    rst = 1'b1;
    fifo_full = 1'b0;
    fifo_empty = 1'b0;
    pop_value = '0;
    bus.sys_addr_i = '0;
    bus.sys_wdata_i = '0;
    bus.sys_sel_i = 4'hf;
    bus.sys_wen_i = 1'b0;
    bus.sys_ren_i = 1'b0;
    @(posedge clk);
    #1;
    bus.sys_addr_i = 32'h20;
    bus.sys_ren_i  = 1'b1;
    tick(2);
    bus.sys_ren_i  = 1'b0;
    chk("rst_ack", 64'(bus.sys_ack_o), 64'd0);
    chk("rst_rdata", 64'(bus.sys_rdata_o), 64'd0);
    chk("rst_outs", 64'({fifo_rst, fifo_wr_en, fifo_rd_en, cnt_clr, cnt_en}), 64'd0);
    rst = 1'b0;
    tick(1);
    bus_rd(32'h0C, 32'h0, "rst_status");
    bus_rd(32'h04, 32'h0, "rst_len");
    bus_rd(32'h08, 32'h0, "rst_div");
    bus_rd(32'h14, 32'h0, "rst_captured");
    bus_rd(32'h18, 32'h0, "rst_data_lo");

    // basic capture: LEN=5, DIV=2
    bus_wr(32'h04, 32'd5);
    bus_wr(32'h08, 32'd2);
    bus_rd(32'h04, 32'd5, "a_len_rb");
    wb = wr_cnt; rb = rst_cnt; cb = clr_cnt;
    bus_wr(32'h00, 32'h1);
    for (int i = 0; i < 200 && (wr_cnt - wb) < 5; i++) tick(1);
    chk("a_wr_timeout", 64'((wr_cnt - wb) >= 5), 64'd1);
    tick(3);
    chk("a_rst_cycles", 64'(rst_cnt - rb), 64'd4);
    chk("a_clr_cycles", 64'(clr_cnt - cb), 64'd4);
    chk("a_wr_count", 64'(wr_cnt - wb), 64'd5);
    for (int k = 1; k < 5; k++)
      chk("a_wr_spacing", 64'(wr_time[wb + k] - wr_time[wb + k - 1]), 64'd3);
    chk("a_cnt_en_off", 64'(cnt_en), 64'd0);
    bus_rd(32'h0C, 32'h3, "a_status");
    bus_rd(32'h14, 32'd5, "a_captured");
    tick(10);
    chk("a_no_extra_wr", 64'(wr_cnt - wb), 64'd5);

    // LEN=0 goes straight to DONE after the flush
    bus_wr(32'h04, 32'd0);
    wb = wr_cnt; rb = rst_cnt;
    bus_wr(32'h00, 32'h1);
    tick(10);
    chk("z_wr_count", 64'(wr_cnt - wb), 64'd0);
    chk("z_rst_cycles", 64'(rst_cnt - rb), 64'd4);
    bus_rd(32'h0C, 32'h3, "z_status");

    // overflow: FIFO fills after two writes
    bus_wr(32'h04, 32'd10);
    wb = wr_cnt;
    bus_wr(32'h00, 32'h1);
    for (int i = 0; i < 200 && (wr_cnt - wb) < 2; i++) tick(1);
    chk("b_wr_timeout", 64'((wr_cnt - wb) >= 2), 64'd1);
    fifo_full = 1'b1;
    tick(15);
    chk("b_wr_count", 64'(wr_cnt - wb), 64'd2);
    bus_rd(32'h0C, 32'h53, "b_status");
    bus_rd(32'h14, 32'd2, "b_captured");
    fifo_full = 1'b0;

    // pop from DONE
    pop_value = 64'h0123_4567_89AB_CDEF;
    rdb = rd_cnt;
    bus_wr(32'h10, 32'h0);
    tick(2);
    chk("c_rd_count", 64'(rd_cnt - rdb), 64'd1);
    bus_rd(32'h18, 32'h89AB_CDEF, "c_data_lo");
    bus_rd(32'h1C, 32'h0123_4567, "c_data_hi");
    bus_rd(32'h0C, 32'h143, "c_status");

    // pop from an empty FIFO, then clear flags
    fifo_empty = 1'b1;
    pop_value  = 64'hFFFF_0000_FFFF_0000;
    rdb = rd_cnt;
    bus_wr(32'h10, 32'h0);
    tick(2);
    chk("d_rd_count", 64'(rd_cnt - rdb), 64'd0);
    bus_rd(32'h0C, 32'h1E3, "d_status_unf");
    bus_rd(32'h1C, 32'h0123_4567, "d_data_hold");
    bus_wr(32'h00, 32'h4);
    bus_rd(32'h0C, 32'h023, "d_status_clr");
    fifo_empty = 1'b0;

    // abort three cycles into CAPTURE with DIV=0
    bus_wr(32'h04, 32'd100);
    bus_wr(32'h08, 32'd0);
    wb = wr_cnt;
    bus_wr(32'h00, 32'h1);
    for (int i = 0; i < 50 && !cnt_en; i++) tick(1);
    chk("e_capture_timeout", 64'(cnt_en), 64'd1);
    tick(2);
    bus_wr(32'h00, 32'h2);
    chk("e_outs_off", 64'({cnt_en, fifo_wr_en, fifo_rst, fifo_rd_en}), 64'd0);
    n = wr_cnt - wb;
    chk("e_wr_ge2", 64'(n >= 2), 64'd1);
    bus_rd(32'h0C, 32'h0, "e_status");
    bus_rd(32'h14, 32'(n), "e_captured");
    tick(5);
    chk("e_no_extra_wr", 64'(wr_cnt - wb), 64'(n));

    // undecoded address and abort+start in IDLE
    bus_rd(32'h20, 32'hFFFF_FFFF, "f_bad_addr");
    bus_wr(32'h20, 32'h1234);
    chk("f_bad_wr_ack", 64'(bus.sys_ack_o), 64'd1);
    chk("f_err", 64'(bus.sys_err_o), 64'd0);
    rb = rst_cnt;
    bus_wr(32'h00, 32'h3);
    tick(3);
    chk("f_no_flush", 64'(rst_cnt - rb), 64'd0);
    bus_rd(32'h0C, 32'h0, "f_status");

    // reset in the middle of a capture
    bus_wr(32'h04, 32'd50);
    bus_wr(32'h00, 32'h1);
    for (int i = 0; i < 50 && !cnt_en; i++) tick(1);
    chk("g_capture_timeout", 64'(cnt_en), 64'd1);
    tick(2);
    rst = 1'b1;
    tick(1);
    wb = wr_cnt; rb = rst_cnt;
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("g_wr_stopped", 64'(wr_cnt - wb), 64'd0);
    chk("g_no_flush", 64'(rst_cnt - rb), 64'd0);
    bus_rd(32'h04, 32'h0, "g_len");
    bus_rd(32'h0C, 32'h0, "g_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
